// File: rtl/pc_sequencer.sv
// Program-counter sequencer and run controller.
// Owns the Start/Done handshake and steps prog_ctr once per instruction.
// Taken branches are either relative (signed offset) or absolute (LUT target).
// Multi-cycle memory ops hold the current PC for STALL_CYC extra cycles.
module pc_sequencer #(
  parameter int PC_W      = 10,
  parameter int OFFSET_W  = 8,
  parameter int STALL_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [PC_W-1:0]     start_addr,
  input  logic                halt,
  input  logic                stall_req,
  input  logic                jump_en,
  input  logic                immOrLUT,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic [PC_W-1:0]     lut_target,
  output logic [PC_W-1:0]     prog_ctr,
  output logic                instr_valid,
  output logic                Done,
  output logic [CNT_W-1:0]    cycle_cnt
);

  localparam int SC_W = (STALL_CYC < 1) ? 1 : $clog2(STALL_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, STALL, DONE} state_t;

  state_t            state_q, state_d;
  logic [SC_W-1:0]   stall_cnt, stall_cnt_d;
  logic [PC_W-1:0]   pc_d;
  logic              vld_d, done_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [PC_W-1:0]   off_ext;
  logic [PC_W-1:0]   pc_inc;

  // Sign-extend the relative offset; the add wraps modulo 2**PC_W.
  assign off_ext = PC_W'($signed(br_offset));
  assign pc_inc  = prog_ctr + PC_W'(1);

  // State and registered outputs; reset clears everything without a clock.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      prog_ctr    <= '0;
      instr_valid <= 1'b0;
      Done        <= 1'b0;
      cycle_cnt   <= '0;
      stall_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      prog_ctr    <= pc_d;
      instr_valid <= vld_d;
      Done        <= done_d;
      cycle_cnt   <= cnt_d;
      stall_cnt   <= stall_cnt_d;
    end
  end

  // Next state and next outputs; priority in RUN is halt > stall > jump > inc.
  always_comb begin
    state_d     = state_q;
    pc_d        = prog_ctr;
    vld_d       = instr_valid;
    done_d      = Done;
    cnt_d       = cycle_cnt;
    stall_cnt_d = stall_cnt;

    // Count every active cycle (including the halt cycle), saturating.
    if ((state_q == RUN || state_q == STALL) && (cycle_cnt != '1))
      cnt_d = cycle_cnt + CNT_W'(1);

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d     = RUN;
          pc_d        = start_addr;
          vld_d       = 1'b1;
          done_d      = 1'b0;
          cnt_d       = '0;
          stall_cnt_d = '0;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = DONE;
          vld_d   = 1'b0;
          done_d  = 1'b1;
        end else if (stall_req) begin
          state_d     = STALL;
          vld_d       = 1'b0;
          stall_cnt_d = SC_W'(STALL_CYC);
        end else if (jump_en) begin
          pc_d = immOrLUT ? lut_target : (prog_ctr + off_ext);
        end else begin
          pc_d = pc_inc;
        end
      end
      STALL: begin
        // Stalled ops never branch or halt; just wait out the counter.
        if (stall_cnt <= SC_W'(1)) begin
          state_d     = RUN;
          pc_d        = pc_inc;
          vld_d       = 1'b1;
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_cnt - SC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (STALL_CYC=2, CNT_W=4 to reach saturation).
module tb_pc_sequencer;

  localparam int PC_W = 10;
  localparam int OFFSET_W = 8;
  localparam int CNT_W = 4;

  logic                Clk = 1'b0;
  logic                Reset;
  logic                Start;
  logic [PC_W-1:0]     start_addr;
  logic                halt, stall_req, jump_en, immOrLUT;
  logic [OFFSET_W-1:0] br_offset;
  logic [PC_W-1:0]     lut_target;
  logic [PC_W-1:0]     prog_ctr;
  logic                instr_valid, Done;
  logic [CNT_W-1:0]    cycle_cnt;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.PC_W(PC_W), .OFFSET_W(OFFSET_W), .STALL_CYC(2), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .start_addr(start_addr),
    .halt(halt), .stall_req(stall_req), .jump_en(jump_en), .immOrLUT(immOrLUT),
    .br_offset(br_offset), .lut_target(lut_target), .prog_ctr(prog_ctr),
    .instr_valid(instr_valid), .Done(Done), .cycle_cnt(cycle_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic            start;
    logic [PC_W-1:0] addr;
    logic            hlt, stl, jmp, imm;
    logic [7:0]      off;
    logic [PC_W-1:0] lut;
    logic [PC_W-1:0] pc;
    logic            vld, done;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input logic s, input logic [9:0] a, input logic h,
                              input logic st, input logic j, input logic im,
                              input logic [7:0] o, input logic [9:0] l,
                              input logic [9:0] p, input logic v, input logic d,
                              input logic [3:0] c);
    vec_t r;
    r.start = s; r.addr = a; r.hlt = h; r.stl = st; r.jmp = j; r.imm = im;
    r.off = o; r.lut = l; r.pc = p; r.vld = v; r.done = d; r.cnt = c;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Start = v.start; start_addr = v.addr; halt = v.hlt; stall_req = v.stl;
    jump_en = v.jmp; immOrLUT = v.imm; br_offset = v.off; lut_target = v.lut;
  endtask

  task automatic check_outs(input int idx, input logic [9:0] pc, input logic v,
                            input logic d, input logic [3:0] c);
    check("prog_ctr", idx, 32'(prog_ctr), 32'(pc));
    check("instr_valid", idx, 32'(instr_valid), 32'(v));
    check("Done", idx, 32'(Done), 32'(d));
    check("cycle_cnt", idx, 32'(cycle_cnt), 32'(c));
  endtask

  // Drive at negedge, clock once, compare 2ns after the edge, return to negedge.
  task automatic step(input int idx, input vec_t v);
    drive(v);
    @(posedge Clk);
    #2;
    check_outs(idx, v.pc, v.vld, v.done, v.cnt);
    @(negedge Clk);
  endtask

  vec_t idle_v;

  initial begin
    idle_v = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    drive(idle_v);
    Reset = 1'b0;
    #12;
    check_outs(100, 10'h000, 0, 0, 4'd0);
    @(negedge Clk);
    Reset = 1'b1;

    //             st addr    h st j im off    lut      pc      v d cnt
    vecs[0]  = mk(1, 10'h010, 0, 0, 0, 0, 8'h00, 10'h000, 10'h010, 1, 0, 4'd0);
    vecs[1]  = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h011, 1, 0, 4'd1);
    vecs[2]  = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h012, 1, 0, 4'd2);
    vecs[3]  = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h013, 1, 0, 4'd3);
    vecs[4]  = mk(0, 10'h000, 0, 0, 1, 1, 8'h00, 10'h020, 10'h020, 1, 0, 4'd4);
    vecs[5]  = mk(0, 10'h000, 0, 0, 1, 0, 8'hFC, 10'h000, 10'h01C, 1, 0, 4'd5);
    vecs[6]  = mk(0, 10'h000, 0, 0, 1, 1, 8'h00, 10'h3F0, 10'h3F0, 1, 0, 4'd6);
    vecs[7]  = mk(0, 10'h000, 0, 0, 1, 1, 8'h00, 10'h3FF, 10'h3FF, 1, 0, 4'd7);
    vecs[8]  = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h000, 1, 0, 4'd8);
    vecs[9]  = mk(0, 10'h000, 0, 0, 1, 1, 8'h00, 10'h3FF, 10'h3FF, 1, 0, 4'd9);
    vecs[10] = mk(0, 10'h000, 0, 0, 1, 0, 8'h02, 10'h000, 10'h001, 1, 0, 4'd10);
    vecs[11] = mk(1, 10'h200, 0, 0, 0, 0, 8'h00, 10'h000, 10'h002, 1, 0, 4'd11);
    vecs[12] = mk(0, 10'h000, 1, 0, 0, 0, 8'h00, 10'h000, 10'h002, 0, 1, 4'd12);
    vecs[13] = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h002, 0, 1, 4'd12);
    vecs[14] = mk(0, 10'h000, 0, 1, 1, 1, 8'h00, 10'h111, 10'h002, 0, 1, 4'd12);
    vecs[15] = mk(1, 10'h050, 0, 0, 0, 0, 8'h00, 10'h000, 10'h050, 1, 0, 4'd0);
    vecs[16] = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h051, 1, 0, 4'd1);
    vecs[17] = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h052, 1, 0, 4'd2);
    vecs[18] = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h053, 1, 0, 4'd3);
    vecs[19] = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h054, 1, 0, 4'd4);
    vecs[20] = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h055, 1, 0, 4'd5);
    vecs[21] = mk(0, 10'h000, 1, 0, 0, 0, 8'h00, 10'h000, 10'h055, 0, 1, 4'd6);
    vecs[22] = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h055, 0, 1, 4'd6);
    vecs[23] = mk(1, 10'h0A0, 0, 0, 0, 0, 8'h00, 10'h000, 10'h0A0, 1, 0, 4'd0);
    vecs[24] = mk(0, 10'h000, 0, 0, 1, 1, 8'h00, 10'h040, 10'h040, 1, 0, 4'd1);
    // Stall with a taken branch: PC held two cycles, then falls through to +1.
    vecs[25] = mk(0, 10'h000, 0, 1, 1, 1, 8'h00, 10'h100, 10'h040, 0, 0, 4'd2);
    vecs[26] = mk(0, 10'h000, 1, 1, 1, 1, 8'h00, 10'h100, 10'h040, 0, 0, 4'd3);
    vecs[27] = mk(0, 10'h000, 1, 0, 1, 0, 8'h10, 10'h100, 10'h041, 1, 0, 4'd4);
    vecs[28] = mk(0, 10'h000, 1, 1, 0, 0, 8'h00, 10'h000, 10'h041, 0, 1, 4'd5);
    vecs[29] = mk(1, 10'h3FE, 0, 0, 0, 0, 8'h00, 10'h000, 10'h3FE, 1, 0, 4'd0);
    vecs[30] = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h3FF, 1, 0, 4'd1);
    vecs[31] = mk(0, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h000, 1, 0, 4'd2);

    for (int i = 0; i < 32; i++) step(i, vecs[i]);

    // Asynchronous reset mid-run at 0x025: outputs clear before the next edge.
    step(200, mk(0, 10'h000, 0, 0, 1, 1, 8'h00, 10'h025, 10'h025, 1, 0, 4'd3));
    drive(idle_v);
    #2 Reset = 1'b0;
    #1 check_outs(201, 10'h000, 0, 0, 4'd0);
    #1 Reset = 1'b1;
    step(202, idle_v);

    // Long run: cycle_cnt saturates at all-ones while the PC keeps stepping.
    step(300, mk(1, 10'h000, 0, 0, 0, 0, 8'h00, 10'h000, 10'h000, 1, 0, 4'd0));
    for (int k = 0; k < 20; k++) begin
      drive(idle_v);
      @(posedge Clk);
      @(negedge Clk);
    end
    check_outs(301, 10'h014, 1, 0, 4'hF);
    step(302, mk(0, 10'h000, 1, 0, 0, 0, 8'h00, 10'h000, 10'h014, 0, 1, 4'hF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
